// File: rtl/spi_ram_arbiter_pkg.sv
// Shared definitions for the SPI RAM command arbiter: RAM command codes,
// FSM state encoding and the command-word builder.
package spi_ram_arbiter_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ADDR    = 2'b01,
    S_DATA    = 2'b10,
    S_WAIT_RD = 2'b11
  } state_t;

  function automatic logic [9:0] cmd_word(input logic [1:0] cmd, input logic [7:0] payload);
    return {cmd, payload};
  endfunction

endpackage

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins outright; on contention
// the requester that was not served last wins.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_served,
  output logic       o_grant,
  output logic       o_any
);

  always_comb begin
    o_any   = |i_valid;
    o_grant = 1'b0;
    unique case (i_valid)
      2'b01:   o_grant = 1'b0;
      2'b10:   o_grant = 1'b1;
      2'b11:   o_grant = ~i_last_served;
      default: o_grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares the SPI RAM command port between two requesters: serialises each
// transaction into two 10-bit command words and routes read data back.
module spi_ram_arbiter
  import spi_ram_arbiter_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_WIDTH = 8,
  parameter int TIMEOUT   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_wr,
  input  logic [ADDR_SIZE-1:0] req0_addr,
  input  logic [MEM_WIDTH-1:0] req0_wdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_wr,
  input  logic [ADDR_SIZE-1:0] req1_addr,
  input  logic [MEM_WIDTH-1:0] req1_wdata,
  output logic                 rsp0_valid,
  output logic [MEM_WIDTH-1:0] rsp0_rdata,
  output logic                 rsp0_err,
  output logic                 rsp1_valid,
  output logic [MEM_WIDTH-1:0] rsp1_rdata,
  output logic                 rsp1_err,
  output logic [9:0]           ram_din,
  output logic                 ram_rx_valid,
  input  logic [MEM_WIDTH-1:0] ram_dout,
  input  logic                 ram_tx_valid
);

  state_t                 r_state, w_next_state;
  logic                   r_last_served;
  logic                   r_owner;
  logic                   r_wr;
  logic [ADDR_SIZE-1:0]   r_addr;
  logic [MEM_WIDTH-1:0]   r_wdata;
  logic [3:0]             r_cnt;
  logic                   w_grant, w_any, w_accept, w_timeout, w_rsp_fire;

  rr_arb2 u_arb (
    .i_valid       ({req1_valid, req0_valid}),
    .i_last_served (r_last_served),
    .o_grant       (w_grant),
    .o_any         (w_any)
  );

  assign w_timeout  = (r_cnt == 4'(TIMEOUT - 1));
  assign w_rsp_fire = (r_state == S_WAIT_RD) && (ram_tx_valid || w_timeout);

  // NOTE: every combinational output is given a default before the case so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    ram_rx_valid = 1'b0;
    ram_din      = '0;
    unique case (r_state)
      S_IDLE: begin
        req0_ready = w_any && !w_grant;
        req1_ready = w_any && w_grant;
        if (w_any) begin
          w_accept     = 1'b1;
          w_next_state = S_ADDR;
        end
      end
      S_ADDR: begin
        ram_rx_valid = 1'b1;
        ram_din      = cmd_word(r_wr ? CMD_WR_ADDR : CMD_RD_ADDR, r_addr);
        w_next_state = S_DATA;
      end
      S_DATA: begin
        ram_rx_valid = 1'b1;
        ram_din      = cmd_word(r_wr ? CMD_WR_DATA : CMD_RD_DATA, r_wr ? r_wdata : '0);
        w_next_state = r_wr ? S_IDLE : S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (w_rsp_fire) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_served <= 1'b1;
      r_owner       <= 1'b0;
      r_wr          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
    end else if (w_accept) begin
      r_last_served <= w_grant;
      r_owner       <= w_grant;
      r_wr          <= w_grant ? req1_wr    : req0_wr;
      r_addr        <= w_grant ? req1_addr  : req0_addr;
      r_wdata       <= w_grant ? req1_wdata : req0_wdata;
    end
  end

  // Held at zero outside WAIT_RD, so every read starts its timeout window fresh.
  always_ff @(posedge clk) begin
    if (!rst_n)                     r_cnt <= '0;
    else if (r_state != S_WAIT_RD)  r_cnt <= '0;
    else if (!ram_tx_valid)         r_cnt <= r_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (w_rsp_fire) begin
        if (!r_owner) begin
          rsp0_valid <= 1'b1;
          rsp0_rdata <= ram_tx_valid ? ram_dout : '0;
          rsp0_err   <= !ram_tx_valid;
        end else begin
          rsp1_valid <= 1'b1;
          rsp1_rdata <= ram_tx_valid ? ram_dout : '0;
          rsp1_err   <= !ram_tx_valid;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter: a RAM model, a command/response
// scoreboard and latency checks around arbitration, timeout and reset.
module tb_spi_ram_arbiter;

  localparam int TIMEOUT = 4;

  logic       clk, rst_n;
  logic       req0_valid, req0_ready, req0_wr;
  logic [7:0] req0_addr, req0_wdata;
  logic       req1_valid, req1_ready, req1_wr;
  logic [7:0] req1_addr, req1_wdata;
  logic       rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic [9:0] ram_din;
  logic       ram_rx_valid, ram_tx_valid;
  logic [7:0] ram_dout;

  spi_ram_arbiter #(.ADDR_SIZE(8), .MEM_WIDTH(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
  );

  typedef struct {
    int         port;
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  logic [9:0] exp_cmd[$];
  rsp_t       exp_rsp[$];
  logic [7:0] shadow[256];
  logic [7:0] mem[256];

  int  n_pass = 0, n_total = 0;
  int  cyc = 0, n_rx = 0, n_rsp = 0, rsp_cyc = 0;
  bit  mon_en = 0, suppress = 0, force_tx = 0, pending = 0;
  logic [7:0] wa = 0, ra = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RAM model: answers RD_DATA in the first WAIT_RD cycle unless suppressed.
  initial begin
    ram_tx_valid = 0;
    ram_dout     = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    forever begin
      @(posedge clk); #1;
      ram_tx_valid = (pending && !suppress) || force_tx;
      ram_dout     = (pending && !suppress) ? mem[ra] : 8'hEE;
      pending      = 0;
      force_tx     = 0;
      @(negedge clk);
      if (ram_rx_valid) begin
        case (ram_din[9:8])
          2'b00: wa = ram_din[7:0];
          2'b01: mem[wa] = ram_din[7:0];
          2'b10: ra = ram_din[7:0];
          2'b11: pending = 1;
        endcase
      end
    end
  end

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ram_rx_valid) begin
        n_rx++;
        if (exp_cmd.size() == 0) check("cmd_unexpected", exp_cmd.size(), 1);
        else check("cmd_word", ram_din, exp_cmd.pop_front());
      end
      if (rsp0_valid || rsp1_valid) begin
        n_rsp++;
        rsp_cyc = cyc;
        if (exp_rsp.size() == 0) check("rsp_unexpected", exp_rsp.size(), 1);
        else begin
          rsp_t e;
          e = exp_rsp.pop_front();
          check("rsp_port", {rsp1_valid, rsp0_valid}, (e.port == 1) ? 2'b10 : 2'b01);
          check("rsp_rdata", (e.port == 1) ? rsp1_rdata : rsp0_rdata, e.rdata);
          check("rsp_err", (e.port == 1) ? rsp1_err : rsp0_err, e.err);
        end
      end
    end
  end

  task automatic exp_write(input logic [7:0] a, input logic [7:0] d);
    exp_cmd.push_back({2'b00, a});
    exp_cmd.push_back({2'b01, d});
    shadow[a] = d;
  endtask

  task automatic exp_read(input int p, input logic [7:0] a, input bit timeout);
    rsp_t e;
    exp_cmd.push_back({2'b10, a});
    exp_cmd.push_back({2'b11, 8'h00});
    e.port  = p;
    e.rdata = timeout ? 8'h00 : shadow[a];
    e.err   = timeout;
    exp_rsp.push_back(e);
  endtask

  // Caller is at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic do_req(input int p, input logic wr, input logic [7:0] a, input logic [7:0] d,
                        output int acc);
    bit   ok;
    logic rdy;
    ok = 0;
    if (p == 0) begin
      req0_valid = 1; req0_wr = wr; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = 1; req1_wr = wr; req1_addr = a; req1_wdata = d;
    end
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      rdy = (p == 0) ? req0_ready : req1_ready;
      @(posedge clk); #1;
      if (rdy) ok = 1;
    end
    if (p == 0) req0_valid = 0;
    else        req1_valid = 0;
    acc = cyc;
    check($sformatf("req%0d_accept", p), ok, 1);
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 64 && n_rsp < target; i++) @(posedge clk);
    #1;
    check("rsp_arrived", n_rsp >= target, 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int a0, a1, a2, a3, acc, rsp_before, rx_before;
    for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'h5A;
    rst_n = 0;
    req0_valid = 0; req0_wr = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_wr = 0; req1_addr = 0; req1_wdata = 0;
    idle_cycles(3);

    @(negedge clk);
    check("rst_rx_valid", ram_rx_valid, 0);
    check("rst_din", ram_din, 0);
    check("rst_ready", {req1_ready, req0_ready}, 0);
    check("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    check("rst_rsp_rdata", {rsp1_rdata, rsp0_rdata}, 0);
    check("rst_rsp_err", {rsp1_err, rsp0_err}, 0);
    @(posedge clk); #1;
    rst_n  = 1;
    mon_en = 1;
    idle_cycles(1);

    // Contention from reset: order 0,1,0,1.
    exp_read(0, 8'h10, 0);
    exp_read(1, 8'h20, 0);
    exp_read(0, 8'h11, 0);
    exp_read(1, 8'h21, 0);
    fork
      begin do_req(0, 0, 8'h10, 8'h00, a0); do_req(0, 0, 8'h11, 8'h00, a2); end
      begin do_req(1, 0, 8'h20, 8'h00, a1); do_req(1, 0, 8'h21, 8'h00, a3); end
    join
    check("rr_order_0_before_1", a1 > a0, 1);
    check("rr_order_1_before_0", a2 > a1, 1);
    check("rr_order_0_before_1b", a3 > a2, 1);
    wait_rsp(4);

    // Write then read back 8'h3C.
    exp_cmd.push_back(10'h03C);
    exp_cmd.push_back(10'h1A5);
    shadow[8'h3C] = 8'hA5;
    exp_cmd.push_back(10'h23C);
    exp_cmd.push_back(10'h300);
    begin
      rsp_t e;
      e.port = 0; e.rdata = 8'hA5; e.err = 0;
      exp_rsp.push_back(e);
    end
    do_req(0, 1, 8'h3C, 8'hA5, a0);
    do_req(0, 0, 8'h3C, 8'h00, acc);
    check("wr_then_rd_spacing", acc - a0, 3);
    wait_rsp(5);
    check("rd_latency", rsp_cyc - acc, 3);

    // Back-to-back writes from requester 1: 2 command words every 3 cycles.
    rx_before = n_rx;
    exp_write(8'h40, 8'h90);
    exp_write(8'h41, 8'h91);
    exp_write(8'h42, 8'h92);
    exp_write(8'h43, 8'h93);
    do_req(1, 1, 8'h40, 8'h90, a0);
    do_req(1, 1, 8'h41, 8'h91, a1);
    do_req(1, 1, 8'h42, 8'h92, a2);
    do_req(1, 1, 8'h43, 8'h93, a3);
    check("b2b_span", a3 - a0, 9);
    idle_cycles(2);
    check("b2b_rx_count", n_rx - rx_before, 8);
    exp_read(1, 8'h42, 0);
    do_req(1, 0, 8'h42, 8'h00, acc);
    wait_rsp(6);

    // Timeout: RAM stays silent.
    suppress = 1;
    exp_read(0, 8'h50, 1);
    do_req(0, 0, 8'h50, 8'h00, acc);
    wait_rsp(7);
    check("timeout_latency", rsp_cyc - acc, TIMEOUT + 2);
    suppress = 0;

    // Stray ram_tx_valid while idle must not produce a response.
    rsp_before = n_rsp;
    @(negedge clk);
    force_tx = 1;
    idle_cycles(5);
    check("stray_no_rsp", n_rsp, rsp_before);
    check("rsp0_err_hold", rsp0_err, 1);
    check("rsp0_rdata_hold", rsp0_rdata, 0);

    // Reset during the DATA cycle of a read.
    rsp_before = n_rsp;
    exp_cmd.push_back({2'b10, 8'h60});
    exp_cmd.push_back({2'b11, 8'h00});
    do_req(0, 0, 8'h60, 8'h00, acc);
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_rx_valid", ram_rx_valid, 0);
    check("rst_mid_din", ram_din, 0);
    check("rst_mid_rsp_err", rsp0_err, 0);
    @(posedge clk); #1;
    rst_n = 1;
    idle_cycles(8);
    check("rst_mid_no_rsp", n_rsp, rsp_before);

    // After reset requester 0 wins the first contention again.
    exp_read(0, 8'h70, 0);
    exp_read(1, 8'h71, 0);
    fork
      do_req(0, 0, 8'h70, 8'h00, a0);
      do_req(1, 0, 8'h71, 8'h00, a1);
    join
    check("post_rst_rr_order", a1 > a0, 1);
    wait_rsp(rsp_before + 2);

    idle_cycles(3);
    check("cmd_queue_drained", exp_cmd.size(), 0);
    check("rsp_queue_drained", exp_rsp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench did not finish");
  end

endmodule
